// File: rtl/frame_ram_pkg.sv
// Shared types and default sizes for the frame RAM write-port scheduler.
// Holds the scheduler state encoding, which is also the debug state_code value.
// Default geometry is a 640x480 frame of RGB444 pixels.
package frame_ram_pkg;

    localparam int          ADDR_W_DEF       = 19;
    localparam int          DATA_W_DEF       = 12;
    localparam int unsigned FRAME_PIXELS_DEF = 640 * 480;
    localparam int unsigned TIMEOUT_DEF      = 1048576;
    localparam int          ERR_W_DEF        = 8;

    // Encoding doubles as the externally visible state_code
    typedef enum logic [2:0] {
        ST_LIVE   = 3'd0,
        ST_DRAIN  = 3'd1,
        ST_FROZEN = 3'd2,
        ST_PROC   = 3'd3,
        ST_RESYNC = 3'd4
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Latency: count updates one cycle after inc/clr.
// Backpressure: none; increments at all-ones are absorbed.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear wins, otherwise step unless already saturated
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/frame_ram_scheduler.sv
// Arbitrates frame RAM port A between live camera capture and the still-image processor, freezing on frame boundaries.
// Latency: an accepted write appears on the registered ram_* outputs one cycle later.
// Backpressure: camera has none (writes dropped when not forwarded); processor held off by proc_wr_ready outside PROC.
module frame_ram_scheduler
    import frame_ram_pkg::*;
#(
    parameter int          ADDR_W       = ADDR_W_DEF,
    parameter int          DATA_W       = DATA_W_DEF,
    parameter int unsigned FRAME_PIXELS = FRAME_PIXELS_DEF,
    parameter int unsigned TIMEOUT      = TIMEOUT_DEF,
    parameter int          ERR_W        = ERR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze_req,
    input  logic              proc_go,
    input  logic              proc_done,
    input  logic              cam_frame_start,
    input  logic              cam_wr_valid,
    input  logic [ADDR_W-1:0] cam_wr_addr,
    input  logic [DATA_W-1:0] cam_wr_data,
    input  logic              proc_wr_valid,
    output logic              proc_wr_ready,
    input  logic [ADDR_W-1:0] proc_wr_addr,
    input  logic [DATA_W-1:0] proc_wr_data,
    output logic              ram_ena,
    output logic              ram_wea,
    output logic [ADDR_W-1:0] ram_addra,
    output logic [DATA_W-1:0] ram_dina,
    output logic              proc_start,
    output logic              frozen,
    output logic              timeout_flag,
    output logic [2:0]        state_code,
    output logic [ERR_W-1:0]  addr_err_cnt
);

    localparam int                WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT - 1);
    // One extra bit so a frame filling the whole address space still compares correctly
    localparam logic [ADDR_W:0]   PIX_LIM = (ADDR_W + 1)'(FRAME_PIXELS);

    state_t              state_q,      state_d;
    logic [WD_W-1:0]     wd_q,         wd_d;
    logic                timeout_q,    timeout_d;
    logic                proc_start_q, proc_start_d;
    logic                ram_ena_q,    ram_ena_d;
    logic [ADDR_W-1:0]   ram_addra_q,  ram_addra_d;
    logic [DATA_W-1:0]   ram_dina_q,   ram_dina_d;

    logic                proc_acc;
    logic                wr_vld;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic                addr_ok;
    logic                err_inc;

    assign proc_wr_ready = (state_q == ST_PROC);
    assign proc_acc      = proc_wr_valid && proc_wr_ready;

    // Next state, watchdog, write-source selection and registered RAM port values
    always_comb begin
        state_d      = state_q;
        wd_d         = wd_q;
        timeout_d    = timeout_q;
        proc_start_d = 1'b0;
        wr_vld       = 1'b0;
        wr_addr      = cam_wr_addr;
        wr_data      = cam_wr_data;

        case (state_q)
            ST_LIVE: begin
                wr_vld = cam_wr_valid;
                if (freeze_req) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // The write coinciding with frame start already belongs to the next frame
                if (cam_frame_start) begin
                    state_d = ST_FROZEN;
                end else begin
                    wr_vld = cam_wr_valid;
                    if (!freeze_req) begin
                        state_d = ST_LIVE;
                    end
                end
            end
            ST_FROZEN: begin
                if (!freeze_req) begin
                    state_d = ST_RESYNC;
                end else if (proc_go) begin
                    state_d      = ST_PROC;
                    proc_start_d = 1'b1;
                    wd_d         = '0;
                end
            end
            ST_PROC: begin
                wr_vld  = proc_acc;
                wr_addr = proc_wr_addr;
                wr_data = proc_wr_data;
                if (proc_acc) begin
                    wd_d = '0;
                end else if (wd_q != WD_LAST) begin
                    wd_d = wd_q + 1'b1;
                end
                if (proc_done) begin
                    state_d = ST_FROZEN;
                end else if (!proc_acc && (wd_q == WD_LAST)) begin
                    state_d   = ST_FROZEN;
                    timeout_d = 1'b1;
                end
            end
            ST_RESYNC: begin
                // Re-freezing keeps the untouched buffer; otherwise rejoin on a clean frame start
                if (freeze_req) begin
                    state_d = ST_FROZEN;
                end else if (cam_frame_start) begin
                    state_d = ST_LIVE;
                    wr_vld  = cam_wr_valid;
                end
            end
            default: begin
                state_d = ST_LIVE;
            end
        endcase

        addr_ok     = ({1'b0, wr_addr} < PIX_LIM);
        ram_ena_d   = wr_vld && addr_ok;
        err_inc     = wr_vld && !addr_ok;
        ram_addra_d = ram_ena_d ? wr_addr : ram_addra_q;
        ram_dina_d  = ram_ena_d ? wr_data : ram_dina_q;
    end

    // State, watchdog and RAM port registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_LIVE;
            wd_q         <= '0;
            timeout_q    <= 1'b0;
            proc_start_q <= 1'b0;
            ram_ena_q    <= 1'b0;
            ram_addra_q  <= '0;
            ram_dina_q   <= '0;
        end else begin
            state_q      <= state_d;
            wd_q         <= wd_d;
            timeout_q    <= timeout_d;
            proc_start_q <= proc_start_d;
            ram_ena_q    <= ram_ena_d;
            ram_addra_q  <= ram_addra_d;
            ram_dina_q   <= ram_dina_d;
        end
    end

    sat_counter #(
        .W (ERR_W)
    ) u_addr_err_cnt (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc (err_inc),
        .cnt (addr_err_cnt)
    );

    assign ram_ena      = ram_ena_q;
    assign ram_wea      = ram_ena_q;
    assign ram_addra    = ram_addra_q;
    assign ram_dina     = ram_dina_q;
    assign proc_start   = proc_start_q;
    assign timeout_flag = timeout_q;
    assign state_code   = state_q;
    assign frozen       = (state_q == ST_FROZEN) || (state_q == ST_PROC);

endmodule

// File: tb/tb_frame_ram_scheduler.sv
// Self-checking bench for frame_ram_scheduler: vector table, directed corner sequences, then randomized traffic against a reference model.
// Latency: outputs are sampled 1 time unit after each rising edge.
// Backpressure: processor writes are only offered; acceptance is inferred from the model's state.
module tb_frame_ram_scheduler;

    localparam int TB_TIMEOUT = 16;
    localparam int PIX        = 307200;

    logic        clk;
    logic        rst;
    logic        freeze_req, proc_go, proc_done, cam_frame_start;
    logic        cam_wr_valid, proc_wr_valid;
    logic [18:0] cam_wr_addr, proc_wr_addr;
    logic [11:0] cam_wr_data, proc_wr_data;
    logic        proc_wr_ready, ram_ena, ram_wea, proc_start, frozen, timeout_flag;
    logic [18:0] ram_addra;
    logic [11:0] ram_dina;
    logic [2:0]  state_code;
    logic [7:0]  addr_err_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    frame_ram_scheduler #(
        .ADDR_W       (19),
        .DATA_W       (12),
        .FRAME_PIXELS (PIX),
        .TIMEOUT      (TB_TIMEOUT),
        .ERR_W        (8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .freeze_req      (freeze_req),
        .proc_go         (proc_go),
        .proc_done       (proc_done),
        .cam_frame_start (cam_frame_start),
        .cam_wr_valid    (cam_wr_valid),
        .cam_wr_addr     (cam_wr_addr),
        .cam_wr_data     (cam_wr_data),
        .proc_wr_valid   (proc_wr_valid),
        .proc_wr_ready   (proc_wr_ready),
        .proc_wr_addr    (proc_wr_addr),
        .proc_wr_data    (proc_wr_data),
        .ram_ena         (ram_ena),
        .ram_wea         (ram_wea),
        .ram_addra       (ram_addra),
        .ram_dina        (ram_dina),
        .proc_start      (proc_start),
        .frozen          (frozen),
        .timeout_flag    (timeout_flag),
        .state_code      (state_code),
        .addr_err_cnt    (addr_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something stalls the stimulus process
    initial begin
        #2000000;
        $display("FAIL global_time_limit: simulation did not finish, reached %0t", $time);
        $fatal(1, "time limit");
    end

    // ---------------- reference model (transaction level) ----------------
    // States: 0 live, 1 draining, 2 frozen, 3 processing, 4 resync
    int          m_state, m_idle, m_err;
    bit          m_flag, m_start, m_ena;
    logic [18:0] m_addr;
    logic [11:0] m_data;

    task automatic model_step();
        bit          wr;
        logic [18:0] a;
        logic [11:0] d;
        int          ns;
        wr = 0; a = cam_wr_addr; d = cam_wr_data; ns = m_state;
        if (rst) begin
            m_state = 0; m_idle = 0; m_err = 0; m_flag = 0; m_start = 0;
            m_ena = 0; m_addr = '0; m_data = '0;
            return;
        end
        m_start = 0;
        if (m_state == 0) begin
            wr = cam_wr_valid;
            if (freeze_req) ns = 1;
        end else if (m_state == 1) begin
            if (cam_frame_start) ns = 2;
            else begin
                wr = cam_wr_valid;
                if (!freeze_req) ns = 0;
            end
        end else if (m_state == 2) begin
            if (!freeze_req) ns = 4;
            else if (proc_go) begin ns = 3; m_start = 1; m_idle = 0; end
        end else if (m_state == 3) begin
            a = proc_wr_addr; d = proc_wr_data;
            if (proc_wr_valid) begin wr = 1; m_idle = 0; end
            if (proc_done) ns = 2;
            else if (!proc_wr_valid) begin
                m_idle++;
                if (m_idle >= TB_TIMEOUT) begin ns = 2; m_flag = 1; end
            end
        end else begin
            if (freeze_req) ns = 2;
            else if (cam_frame_start) begin ns = 0; wr = cam_wr_valid; end
        end
        m_ena = 0;
        if (wr) begin
            if (int'(a) >= PIX) m_err = (m_err >= 255) ? 255 : m_err + 1;
            else begin m_ena = 1; m_addr = a; m_data = d; end
        end
        m_state = ns;
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input int st, input bit ena, input logic [18:0] ad, input logic [11:0] dt,
                             input bit start, input bit flag, input int err);
        chk("state_code",   32'(state_code),    32'(st));
        chk("ram_ena",      32'(ram_ena),       32'(ena));
        chk("ram_wea",      32'(ram_wea),       32'(ena));
        chk("ram_addra",    32'(ram_addra),     32'(ad));
        chk("ram_dina",     32'(ram_dina),      32'(dt));
        chk("proc_start",   32'(proc_start),    32'(start));
        chk("frozen",       32'(frozen),        32'((st == 2) || (st == 3)));
        chk("proc_wr_rdy",  32'(proc_wr_ready), 32'(st == 3));
        chk("timeout_flag", 32'(timeout_flag),  32'(flag));
        chk("addr_err_cnt", 32'(addr_err_cnt),  32'(err));
    endtask

    task automatic idle_inputs();
        proc_go = 0; proc_done = 0; cam_frame_start = 0;
        cam_wr_valid = 0; proc_wr_valid = 0;
        cam_wr_addr = '0; cam_wr_data = '0; proc_wr_addr = '0; proc_wr_data = '0;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        frz, go, done, fs, cv;
        logic [18:0] ca;
        logic [11:0] cd;
        logic        pv;
        logic [18:0] pa;
        logic [11:0] pd;
        int          st;
        logic        ena;
        logic [18:0] ea;
        logic [11:0] ed;
        logic        start;
        int          err;
    } vec_t;

    vec_t vecs[6];

    initial begin
        //          frz go dn fs cv  ca      cd       pv  pa           pd        st ena  ea       ed      st err
        vecs[0] = '{1'b0,1'b0,1'b0,1'b0,1'b1, 19'd5, 12'hABC, 1'b0, 19'd0,      12'h000, 0, 1'b1, 19'd5,   12'hABC, 1'b0, 0};
        vecs[1] = '{1'b1,1'b0,1'b0,1'b0,1'b0, 19'd0, 12'h000, 1'b0, 19'd0,      12'h000, 1, 1'b0, 19'd5,   12'hABC, 1'b0, 0};
        vecs[2] = '{1'b1,1'b0,1'b0,1'b1,1'b1, 19'd0, 12'h555, 1'b0, 19'd0,      12'h000, 2, 1'b0, 19'd5,   12'hABC, 1'b0, 0};
        vecs[3] = '{1'b1,1'b1,1'b0,1'b0,1'b0, 19'd0, 12'h000, 1'b0, 19'd0,      12'h000, 3, 1'b0, 19'd5,   12'hABC, 1'b1, 0};
        vecs[4] = '{1'b1,1'b0,1'b0,1'b0,1'b1, 19'd7, 12'h777, 1'b1, 19'd100,    12'h123, 3, 1'b1, 19'd100, 12'h123, 1'b0, 0};
        vecs[5] = '{1'b1,1'b0,1'b0,1'b0,1'b1, 19'd8, 12'h888, 1'b1, 19'd307200, 12'hFFF, 3, 1'b0, 19'd100, 12'h123, 1'b0, 1};

        rst = 1; freeze_req = 0;
        idle_inputs();
        tick();
        tick();
        rst = 0;
        check_all(0, 0, 19'd0, 12'h000, 0, 0, 0);

        for (int i = 0; i < 6; i++) begin
            freeze_req = vecs[i].frz; proc_go = vecs[i].go; proc_done = vecs[i].done;
            cam_frame_start = vecs[i].fs; cam_wr_valid = vecs[i].cv;
            cam_wr_addr = vecs[i].ca; cam_wr_data = vecs[i].cd;
            proc_wr_valid = vecs[i].pv; proc_wr_addr = vecs[i].pa; proc_wr_data = vecs[i].pd;
            tick();
            check_all(vecs[i].st, vecs[i].ena, vecs[i].ea, vecs[i].ed, vecs[i].start, 0, vecs[i].err);
        end

        // Saturation of the error counter; freeze_req wiggles are ignored in PROC
        for (int i = 0; i < 255; i++) begin
            idle_inputs();
            freeze_req    = i[0];
            cam_wr_valid  = 1; cam_wr_addr = 19'(i);
            proc_wr_valid = 1; proc_wr_addr = 19'(PIX + i); proc_wr_data = 12'(i);
            tick();
            check_all(3, 0, 19'd100, 12'h123, 0, 0, (i + 2 > 255) ? 255 : i + 2);
        end

        // proc_done together with an accepted write: write lands, back to FROZEN
        idle_inputs(); freeze_req = 1;
        proc_wr_valid = 1; proc_wr_addr = 19'd200; proc_wr_data = 12'h0AA; proc_done = 1;
        tick();
        check_all(2, 1, 19'd200, 12'h0AA, 0, 0, 255);

        idle_inputs(); proc_go = 1;
        tick();
        check_all(3, 0, 19'd200, 12'h0AA, 1, 0, 255);

        // Watchdog: no processor writes for TIMEOUT cycles
        idle_inputs();
        for (int i = 1; i <= TB_TIMEOUT; i++) begin
            tick();
            check_all((i < TB_TIMEOUT) ? 3 : 2, 0, 19'd200, 12'h0AA, 0, i == TB_TIMEOUT, 255);
        end

        // Release beats proc_go
        idle_inputs(); freeze_req = 0; proc_go = 1;
        tick();
        check_all(4, 0, 19'd200, 12'h0AA, 0, 1, 255);

        // Clean frame start rejoins live; that cycle's write is forwarded
        idle_inputs(); cam_frame_start = 1; cam_wr_valid = 1; cam_wr_addr = 19'd0; cam_wr_data = 12'h321;
        tick();
        check_all(0, 1, 19'd0, 12'h321, 0, 1, 255);

        idle_inputs(); freeze_req = 1;
        tick();
        check_all(1, 0, 19'd0, 12'h321, 0, 1, 255);
        cam_frame_start = 1;
        tick();
        check_all(2, 0, 19'd0, 12'h321, 0, 1, 255);
        idle_inputs(); proc_go = 1;
        tick();
        check_all(3, 0, 19'd0, 12'h321, 1, 1, 255);

        // Reset mid-PROC with pending writes on both sources
        idle_inputs(); rst = 1; proc_wr_valid = 1; proc_wr_addr = 19'd9; proc_wr_data = 12'h999;
        cam_wr_valid = 1; cam_wr_addr = 19'd3; proc_done = 1;
        tick();
        check_all(0, 0, 19'd0, 12'h000, 0, 0, 0);
        rst = 0; idle_inputs(); freeze_req = 0;
        tick();
        check_all(0, 0, 19'd0, 12'h000, 0, 0, 0);

        // Randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 19) == 0) freeze_req = ~freeze_req;
            rst             = ($urandom_range(0, 599) == 0);
            proc_go         = ($urandom_range(0, 5) == 0);
            proc_done       = ($urandom_range(0, 29) == 0);
            cam_frame_start = ($urandom_range(0, 24) == 0);
            cam_wr_valid    = $urandom_range(0, 1) == 1;
            proc_wr_valid   = ($urandom_range(0, 2) == 0);
            cam_wr_addr     = ($urandom_range(0, 9) == 0) ? 19'(PIX + $urandom_range(0, 200000))
                                                          : 19'($urandom_range(0, PIX - 1));
            proc_wr_addr    = ($urandom_range(0, 4) == 0) ? 19'(PIX + $urandom_range(0, 3))
                                                          : 19'($urandom_range(0, PIX - 1));
            cam_wr_data     = 12'($urandom);
            proc_wr_data    = 12'($urandom);
            tick();
            check_all(m_state, m_ena, m_addr, m_data, m_start, m_flag, m_err);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
